// File: rtl/add_seq_pkg.sv
// Shared definitions for the word-serial arbitrated adder: word width,
// FSM state encoding and requester-id type.
package add_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic id_t;

endpackage

// File: rtl/add_seize.sv
// Shared 16-bit adder slice: sum and carry-out (rout) of a + b + cin.
module add_seize
    import add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              rout
);

    assign {rout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_arb.sv
// Two-requester round-robin front end feeding a word-serial adder built on
// one add_seize slice. Optional subtract mode: define ADD_SEQ_ARB_SUB_EN.
module add_seq_arb
    import add_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic                     req1_valid,
    output logic                     req0_ready,
    output logic                     req1_ready,
    input  logic [WORD_W*NWORDS-1:0] req0_a,
    input  logic [WORD_W*NWORDS-1:0] req0_b,
    input  logic [WORD_W*NWORDS-1:0] req1_a,
    input  logic [WORD_W*NWORDS-1:0] req1_b,
    input  logic                     req0_cin,
    input  logic                     req1_cin,
`ifdef ADD_SEQ_ARB_SUB_EN
    input  logic                     req0_sub,
    input  logic                     req1_sub,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_W*NWORDS-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_id,
    output logic                     busy
);

    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t                          state;
    id_t                             last_id;
    id_t                             cur_id;
    id_t                             grant_id;
    logic [NWORDS-1:0][WORD_W-1:0]   a_reg;
    logic [NWORDS-1:0][WORD_W-1:0]   b_reg;
    logic [NWORDS-1:0][WORD_W-1:0]   sum_reg;
    logic                            carry;
    logic [KW-1:0]                   k;
    logic [WORD_W-1:0]               add_b;
    logic [WORD_W-1:0]               add_sum;
    logic                            add_rout;
    logic                            start_carry;
`ifdef ADD_SEQ_ARB_SUB_EN
    logic                            sub_reg;
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_id = id_t'(req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
    assign busy       = (state != IDLE);
    assign rsp_sum    = sum_reg;
    assign rsp_id     = cur_id;

`ifdef ADD_SEQ_ARB_SUB_EN
    // Subtraction is a + ~b + 1, so the seed carry is forced high.
    assign add_b       = sub_reg ? ~b_reg[k] : b_reg[k];
    assign start_carry = grant_id ? (req1_sub | req1_cin) : (req0_sub | req0_cin);
`else
    assign add_b       = b_reg[k];
    assign start_carry = grant_id ? req1_cin : req0_cin;
`endif

    add_seize u_add (
        .a    (a_reg[k]),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .rout (add_rout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_cout  <= 1'b0;
            cur_id    <= 1'b0;
            last_id   <= 1'b1;
            carry     <= 1'b0;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
`ifdef ADD_SEQ_ARB_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_reg  <= grant_id ? req1_a : req0_a;
                        b_reg  <= grant_id ? req1_b : req0_b;
                        carry  <= start_carry;
                        cur_id <= grant_id;
                        k      <= '0;
`ifdef ADD_SEQ_ARB_SUB_EN
                        sub_reg <= grant_id ? req1_sub : req0_sub;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[k] <= add_sum;
                    carry      <= add_rout;
                    k          <= k + 1'b1;
                    if (k == KW'(NWORDS - 1)) begin
                        rsp_cout  <= add_rout;
                        rsp_valid <= 1'b1;
                        k         <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last_id   <= cur_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_arb.sv
// Directed self-checking bench for add_seq_arb (NWORDS=4); the subtract
// scenario is included when ADD_SEQ_ARB_SUB_EN is defined.
module tb_add_seq_arb;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
`ifdef ADD_SEQ_ARB_SUB_EN
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
`endif
    logic         rsp_valid, rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_id, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_seq_arb #(.NWORDS(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_cin   (req0_cin),
        .req1_cin   (req1_cin),
`ifdef ADD_SEQ_ARB_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Handshake one request, then wait (bounded) until rsp_valid; returns
    // the cycle count after the handshake or -1, leaving the DUT in DONE.
    task automatic run_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, output logic acc, output int lat);
        @(negedge clk);
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
`ifdef ADD_SEQ_ARB_SUB_EN
        if (sel) req1_sub = sub; else req0_sub = sub;
`else
        if (sub) $display("[TB] note: sub requested without subtract build");
`endif
        #1;
        acc = sel ? req1_ready : req0_ready;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready} !== 6'b0 || rsp_sum !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got v=%b c=%b id=%b busy=%b sum=%h, expected all 0",
                     rsp_valid, rsp_cout, rsp_id, busy, rsp_sum);
        end
    endtask

    task automatic test_carry_chain();
        logic acc; int lat;
        run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, acc, lat);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("[TB] FAIL carry_accept: got %b expected 1", acc); end
        checks++;
        if (lat != 5) begin failures++; $display("[TB] FAIL carry_latency: got %0d expected 5", lat); end
        checks++;
        if (rsp_sum !== 64'h0000_0000_0001_0000) begin
            failures++; $display("[TB] FAIL carry_sum: got %h expected 0000000000010000", rsp_sum);
        end
        checks++;
        if (rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
            failures++; $display("[TB] FAIL carry_cout_id: got cout=%b id=%b expected 0 0", rsp_cout, rsp_id);
        end
        release_rsp();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL carry_release: got busy=%b v=%b expected 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_wrap();
        logic acc; int lat;
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, acc, lat);
        checks++;
        if (acc !== 1'b1 || lat != 5) begin
            failures++; $display("[TB] FAIL wrap_handshake: got acc=%b lat=%0d expected 1 5", acc, lat);
        end
        checks++;
        if (rsp_sum !== 64'h0 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_result: got sum=%h cout=%b id=%b expected 0 1 1", rsp_sum, rsp_cout, rsp_id);
        end
        release_rsp();
    endtask

    task automatic test_round_robin();
        logic       ids [4];
        logic [W-1:0] sums [4];
        logic       exp_id [4];
        int got = 0;
        exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
        do_reset();
        @(negedge clk);
        req0_a = 64'd1;  req0_b = 64'd2;  req0_cin = 1'b0;
        req1_a = 64'd10; req1_b = 64'd20; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            #1;
            if (busy && (req0_ready || req1_ready)) begin
                checks++; failures++;
                $display("[TB] FAIL rr_ready_while_busy: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
            end
            if (rsp_valid) begin
                ids[got] = rsp_id;
                sums[got] = rsp_sum;
                got++;
                if (got == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if (got != 4) begin failures++; $display("[TB] FAIL rr_count: got %0d responses expected 4", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (ids[i] !== exp_id[i] || sums[i] !== (exp_id[i] ? 64'd31 : 64'd3)) begin
                failures++;
                $display("[TB] FAIL rr_order[%0d]: got id=%b sum=%h expected id=%b sum=%h",
                         i, ids[i], sums[i], exp_id[i], exp_id[i] ? 64'd31 : 64'd3);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_hold();
        logic acc; int lat;
        run_op(1'b0, 64'h1234, 64'h1111, 1'b0, 1'b0, acc, lat);
        req1_valid = 1'b1; req1_a = 64'h5; req1_b = 64'h5; req1_cin = 1'b0;
        checks++;
        if (acc !== 1'b1 || lat != 5) begin
            failures++; $display("[TB] FAIL hold_handshake: got acc=%b lat=%0d expected 1 5", acc, lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 64'h2345 || rsp_cout !== 1'b0 || rsp_id !== 1'b0 ||
                busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d: got v=%b sum=%h c=%b id=%b busy=%b r1=%b expected 1 2345 0 0 1 0",
                         i, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_exit: got busy=%b v=%b r1=%b expected 0 0 1", busy, rsp_valid, req1_ready);
        end
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic seen = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 64'h0001_0001_0001_0001; req1_b = 64'h0; req1_cin = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_accept: got %b expected 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready} !== 6'b0 || rsp_sum !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_run: got v=%b c=%b id=%b busy=%b sum=%h expected all 0",
                     rsp_valid, rsp_cout, rsp_id, busy, rsp_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_response: got activity=%b expected 0", seen); end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_tie_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

`ifdef ADD_SEQ_ARB_SUB_EN
    task automatic test_sub();
        logic acc; int lat;
        run_op(1'b0, 64'd5, 64'd7, 1'b0, 1'b1, acc, lat);
        checks++;
        if (lat != 5 || rsp_sum !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sub_5_7: got lat=%0d sum=%h cout=%b expected 5 FFFFFFFFFFFFFFFE 0", lat, rsp_sum, rsp_cout);
        end
        release_rsp();
        run_op(1'b1, 64'd7, 64'd5, 1'b0, 1'b1, acc, lat);
        checks++;
        if (lat != 5 || rsp_sum !== 64'd2 || rsp_cout !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sub_7_5: got lat=%0d sum=%h cout=%b expected 5 2 1", lat, rsp_sum, rsp_cout);
        end
        release_rsp();
        req0_sub = 1'b0; req1_sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_wrap();
        test_round_robin();
        test_hold();
        test_reset_mid_run();
`ifdef ADD_SEQ_ARB_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
